// File: rtl/ram_sweep_clr.sv
// ram_sweep_clr: single-port synchronous RAM with a registered read port.
// Read-during-write is write-first. A hardware sweep zeroes one word per cycle
// after reset or a ZERO pulse. BUSY reports when requests are refused.
module ram_sweep_clr #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             CLK_,
   input  logic             CLR,
   input  logic             ZERO,
   input  logic             WE,
   input  logic             RE,
   input  logic [AW-1:0]    ADDR,
   input  logic [WIDTH-1:0] DIN,
   output logic [WIDTH-1:0] DOUT,
   output logic             RVALID,
   output logic             BUSY,
   output logic             ERR
);

   // Two-state controller: SWEEP walks the pointer through every word, IDLE serves requests
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SWEEP = 1'b1;

   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

   logic [0:0]       r_state;
   logic [AW-1:0]    r_ptr;
   logic [WIDTH-1:0] r_dout;
   logic             r_rvalid;
   logic             r_err;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic             w_busy;
   logic             w_accept;
   logic             w_wr_ok;
   logic             w_rd_ok;
   logic             w_drop;
   logic             w_sweep_wr;
   logic             w_mem_we;
   logic [AW-1:0]    w_mem_addr;
   logic [WIDTH-1:0] w_mem_din;

   // Request qualification and the shared memory write port
   always_comb begin
      w_busy     = (r_state == S_SWEEP);
      // A ZERO pulse in IDLE starts a sweep and takes precedence over requests
      w_accept   = !w_busy && !ZERO;
      w_wr_ok    = w_accept && WE;
      w_rd_ok    = w_accept && RE;
      w_drop     = (WE || RE) && !w_accept;
      // A ZERO during a sweep only rewinds the pointer; that cycle writes nothing
      w_sweep_wr = w_busy && !ZERO;
      w_mem_we   = !CLR && (w_sweep_wr || w_wr_ok);
      w_mem_addr = w_busy ? r_ptr : ADDR;
      w_mem_din  = w_busy ? '0 : DIN;
   end

   // Sweep controller: reset and ZERO both rewind to word 0, the last word returns to IDLE
   always_ff @(posedge CLK_) begin
      if (CLR) begin
         r_state <= S_SWEEP;
         r_ptr   <= '0;
      end else if (r_state == S_SWEEP) begin
         if (ZERO) begin
            r_ptr <= '0;
         end else begin
            // DEPTH is a power of two, so the increment wraps to 0 after the last word
            r_ptr <= r_ptr + AW'(1);
            if (r_ptr == PTR_LAST) begin
               r_state <= S_IDLE;
            end
         end
      end else if (ZERO) begin
         r_state <= S_SWEEP;
         r_ptr   <= '0;
      end
   end

   // Memory array write port, with no reset so that it maps onto block RAM
   always_ff @(posedge CLK_) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_din;
      end
   end

   // Registered read port: write-first bypass on a same-cycle write, hold when idle
   always_ff @(posedge CLK_) begin
      if (CLR) begin
         r_dout   <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= w_rd_ok;
         if (w_rd_ok) begin
            // Single port, so a concurrent write always targets the read address
            r_dout <= WE ? DIN : r_mem[ADDR];
         end
      end
   end

   // Sticky error flag: any request refused by a sweep or a ZERO pulse, cleared only by CLR
   always_ff @(posedge CLK_) begin
      if (CLR) begin
         r_err <= 1'b0;
      end else if (w_drop) begin
         r_err <= 1'b1;
      end
   end

   assign DOUT   = r_dout;
   assign RVALID = r_rvalid;
   assign BUSY   = w_busy;
   assign ERR    = r_err;

endmodule

// File: tb/tb_ram_sweep_clr.sv
// tb_ram_sweep_clr: drives a 8x4 and a 16x16 instance with the same stimulus
// and compares both against a countdown-based behavioural model every cycle.
module tb_ram_sweep_clr;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        zero = 1'b0;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [3:0]  addr = '0;
   logic [15:0] din = '0;

   logic [7:0]  dout_a;
   logic        rvalid_a, busy_a, err_a;
   logic [15:0] dout_b;
   logic        rvalid_b, busy_b, err_b;

   int n_vec = 0;
   int n_err = 0;
   int cyc_no = 0;

   // model state, index 0 = 8x4 instance, index 1 = 16x16 instance
   int          m_depth [2] = '{4, 16};
   logic [15:0] m_mask  [2] = '{16'h00FF, 16'hFFFF};
   logic [15:0] m_mem   [2][16];
   int          m_left  [2];   // words still to be cleared; 0 means idle
   logic [15:0] m_dout  [2];
   logic        m_rv    [2];
   logic        m_err   [2];

   always #5 clk = ~clk;

   ram_sweep_clr #(.WIDTH(8), .DEPTH(4)) u_dut_a (
      .CLK_(clk), .CLR(clr), .ZERO(zero), .WE(we), .RE(re),
      .ADDR(addr[1:0]), .DIN(din[7:0]),
      .DOUT(dout_a), .RVALID(rvalid_a), .BUSY(busy_a), .ERR(err_a)
   );

   ram_sweep_clr #(.WIDTH(16), .DEPTH(16)) u_dut_b (
      .CLK_(clk), .CLR(clr), .ZERO(zero), .WE(we), .RE(re),
      .ADDR(addr), .DIN(din),
      .DOUT(dout_b), .RVALID(rvalid_b), .BUSY(busy_b), .ERR(err_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h, expected %h", tag, cyc_no, got, exp);
      end
   endtask

   // One clock edge of the behavioural model for instance k
   task automatic model_edge(input int k);
      int a;
      a = int'(addr) % m_depth[k];
      if (clr) begin
         m_left[k] = m_depth[k];
         m_dout[k] = '0;
         m_rv[k]   = 1'b0;
         m_err[k]  = 1'b0;
      end else if (m_left[k] > 0) begin
         m_rv[k] = 1'b0;
         if (we || re) m_err[k] = 1'b1;
         if (zero) m_left[k] = m_depth[k];
         else      m_left[k] = m_left[k] - 1;
         if (m_left[k] == 0)
            for (int i = 0; i < 16; i++) m_mem[k][i] = '0;
      end else if (zero) begin
         m_left[k] = m_depth[k];
         m_rv[k]   = 1'b0;
         if (we || re) m_err[k] = 1'b1;
      end else begin
         if (we) m_mem[k][a] = din & m_mask[k];
         m_rv[k] = re;
         if (re) m_dout[k] = m_mem[k][a];
      end
   endtask

   task automatic cyc(input logic c, input logic z, input logic w, input logic r,
                      input logic [3:0] ad, input logic [15:0] d);
      clr = c; zero = z; we = w; re = r; addr = ad; din = d;
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      cyc_no++;
      #1;
      chk("a_dout",   32'(dout_a),   32'(m_dout[0]));
      chk("a_rvalid", 32'(rvalid_a), 32'(m_rv[0]));
      chk("a_busy",   32'(busy_a),   32'(m_left[0] > 0));
      chk("a_err",    32'(err_a),    32'(m_err[0]));
      chk("b_dout",   32'(dout_b),   32'(m_dout[1]));
      chk("b_rvalid", 32'(rvalid_b), 32'(m_rv[1]));
      chk("b_busy",   32'(busy_b),   32'(m_left[1] > 0));
      chk("b_err",    32'(err_b),    32'(m_err[1]));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_left[k] = m_depth[k]; m_dout[k] = '0; m_rv[k] = 1'b0; m_err[k] = 1'b0;
         for (int i = 0; i < 16; i++) m_mem[k][i] = '0;
      end
      // reset sweep: CLR held for two cycles, then let both sweeps finish
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
      idle(16);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'(i), 16'd0);
      idle(1);
      // write then read, neighbour still zero
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 16'h00A5);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 16'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 16'd0);
      // write-first collision, then plain read back
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 16'h003C);
      idle(1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 16'd0);
      // dropped write during a ZERO sweep sets ERR
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 16'h00FF);
      idle(16);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'd0);
      // reset in the middle of a sweep
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
      idle(2);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
      idle(17);
      // wide instance: 0xBEEF at the top address, then ZERO clears it
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 16'hBEEF);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 16'd0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'd0);
      idle(16);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 16'd0);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
             1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
